// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM command-to-pin controller.
//   SRAM_DATA_W : default data bus width
//   CMD_*       : write_en command encodings (2'b01 decodes as idle)
//   state_e     : controller state
//   decode_cmd  : maps a write_en command to the state it selects
package sram_ctrl_pkg;

  localparam int SRAM_DATA_W = 16;

  localparam logic [1:0] CMD_WRITE = 2'b11;
  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_IDLE  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  // Any encoding other than WRITE or READ parks the controller in idle.
  function automatic state_e decode_cmd(input logic [1:0] cmd);
    state_e st;
    case (cmd)
      CMD_WRITE: st = S_WRITE;
      CMD_READ:  st = S_READ;
      CMD_IDLE:  st = S_IDLE;
      default:   st = S_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_io_pad.sv
// Tri-state driver for the shared SRAM data pins. Keeps the inout net out of
// the control logic.
//   bus        : SRAM data pins (inout)
//   out_data_i : word to drive onto the pins
//   out_en_i   : 1 = drive out_data_i, 0 = release the pins (high-Z)
//   in_data_o  : current value seen on the pins
module sram_io_pad #(
  parameter int DATA_W = 16
) (
  inout  wire  [DATA_W-1:0] bus,
  input  logic [DATA_W-1:0] out_data_i,
  input  logic              out_en_i,
  output logic [DATA_W-1:0] in_data_o
);

  assign bus       = out_en_i ? out_data_i : {DATA_W{1'bz}};
  assign in_data_o = bus;

endmodule

// File: rtl/sram_ctrl.sv
// Registered command-to-pin controller for an asynchronous 16-bit SRAM.
// Each rising edge samples write_en and moves straight to the selected state
// (WRITE, READ or IDLE); every pin is driven from a register.
//   clk, rst       : clock, synchronous active-high reset
//   write_en       : command (11 write, 00 read, 10/01 idle)
//   data_in        : write data, sampled with a write command
//   byte_sel       : lane select, bit0 low byte, bit1 high byte (only when
//                    SRAM_CTRL_BYTE_MASK_EN is defined)
//   bus            : SRAM data pins, driven only in WRITE
//   data_out       : last captured read word
//   chip_en, data_enable, output_enable, LB, UB : CE#, WE#, OE#, LB#, UB#
// Build option: define SRAM_CTRL_BYTE_MASK_EN to add byte_sel and per-lane
// strobes/capture; without it both lanes are always enabled.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        write_en,
  input  logic [DATA_W-1:0] data_in,
`ifdef SRAM_CTRL_BYTE_MASK_EN
  input  logic [1:0]        byte_sel,
`endif
  inout  wire  [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] data_out,
  output logic              chip_en,
  output logic              data_enable,
  output logic              output_enable,
  output logic              LB,
  output logic              UB
);

  state_e              state_q, state_d;
  logic [1:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                drive_q, drive_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic                oe_q, oe_d;
  logic                lb_q, lb_d;
  logic                ub_q, ub_d;
  logic [DATA_W-1:0]   bus_in_s;

  // Replace only the enabled byte lanes of old_w with new_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [1:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    if (be[0]) begin
      res[7:0] = new_w[7:0];
    end else begin
      res[7:0] = old_w[7:0];
    end
    if (be[1]) begin
      res[DATA_W-1:8] = new_w[DATA_W-1:8];
    end else begin
      res[DATA_W-1:8] = old_w[DATA_W-1:8];
    end
    return res;
  endfunction

`ifdef SRAM_CTRL_BYTE_MASK_EN
  assign be_d = byte_sel;
`else
  assign be_d = 2'b11;
`endif

  sram_io_pad #(.DATA_W(DATA_W)) u_pad (
    .bus        (bus),
    .out_data_i (wdata_q),
    .out_en_i   (drive_q),
    .in_data_o  (bus_in_s)
  );

  // Next-state and next-pin values from the command sampled this edge.
  always_comb begin
    state_d = decode_cmd(write_en);
    ce_d    = 1'b1;
    we_d    = 1'b1;
    oe_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    drive_d = 1'b0;
    wdata_d = wdata_q;
    case (state_d)
      S_WRITE: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        drive_d = 1'b1;
        wdata_d = data_in;
      end
      S_READ: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        lb_d = ~be_d[0];
        ub_d = ~be_d[1];
      end
      S_IDLE: begin
        ce_d = 1'b1;
      end
      default: begin
        ce_d = 1'b1;
      end
    endcase
    // The SRAM has had a full cycle with OE# low, so the pins are sampled
    // at the edge that ends a READ state.
    if (state_q == S_READ) begin
      dout_d = merge_lanes(dout_q, bus_in_s, be_q);
    end else begin
      dout_d = dout_q;
    end
  end

  // Controller state and all pin registers; reset overrides any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      be_q    <= 2'b11;
      wdata_q <= {DATA_W{1'b0}};
      dout_q  <= {DATA_W{1'b0}};
      drive_q <= 1'b0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      lb_q    <= 1'b1;
      ub_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      drive_q <= drive_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      lb_q    <= lb_d;
      ub_q    <= ub_d;
    end
  end

  assign data_out      = dout_q;
  assign chip_en       = ce_q;
  assign data_enable   = we_q;
  assign output_enable = oe_q;
  assign LB            = lb_q;
  assign UB            = ub_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural asynchronous SRAM.
// Read expectations are pushed to a scoreboard queue when a READ command is
// driven and popped when the capture edge is due.
module tb_sram_ctrl;

  localparam logic [1:0] C_W = 2'b11;
  localparam logic [1:0] C_R = 2'b00;
  localparam logic [1:0] C_I = 2'b10;
  localparam logic [1:0] C_X = 2'b01;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_READ  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_en;
  logic [15:0] data_in;
  logic [1:0]  byte_sel;
  wire  [15:0] bus;
  logic [15:0] data_out;
  logic        chip_en, data_enable, output_enable, LB, UB;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .data_in       (data_in),
`ifdef SRAM_CTRL_BYTE_MASK_EN
    .byte_sel      (byte_sel),
`endif
    .bus           (bus),
    .data_out      (data_out),
    .chip_en       (chip_en),
    .data_enable   (data_enable),
    .output_enable (output_enable),
    .LB            (LB),
    .UB            (UB)
  );

  // ---------------- SRAM model (address registered like a sequencer) -------
  logic [15:0] mem [0:255];
  logic [7:0]  addr_req;
  logic [7:0]  sram_addr = 8'd0;
  logic        sram_drive;
  logic        tb_keep = 1'b0;

  always @(posedge clk) sram_addr <= addr_req;

  assign sram_drive = !chip_en && !output_enable && data_enable;
  assign bus = sram_drive ? mem[sram_addr] : 16'hzzzz;
  // When the DUT should have released the bus, hold it at a known value so
  // any stray drive from the DUT shows up as a different word.
  assign bus = tb_keep ? 16'h0000 : 16'hzzzz;

  always @(negedge clk) begin
    if (!chip_en && !data_enable) begin
      if (!LB) mem[sram_addr][7:0]  <= bus[7:0];
      if (!UB) mem[sram_addr][15:8] <= bus[15:8];
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [0:255];
  logic [15:0] sb_q [$];
  logic [15:0] proj_dout = 16'h0000;
  logic [15:0] exp_dout  = 16'h0000;
  logic [15:0] exp_wdata = 16'h0000;
  logic [1:0]  exp_state = T_IDLE;
  logic [1:0]  exp_be    = 2'b11;

  function automatic logic [15:0] lane_mix(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[0]) r[7:0]  = n[7:0];
    if (be[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  function automatic logic [1:0] cmd_state(input logic [1:0] c);
    if (c == C_W) return T_WRITE;
    if (c == C_R) return T_READ;
    return T_IDLE;
  endfunction

  task automatic step(input logic [1:0] cmd, input logic [15:0] din, input logic [7:0] a,
                      input logic r, input logic [1:0] bs);
    logic [1:0]  bs_eff;
    logic [1:0]  prev;
    logic [4:0]  exp_pins;
    @(negedge clk);
    #1;
    write_en = cmd;
    data_in  = din;
    addr_req = a;
    rst      = r;
    byte_sel = bs;
`ifdef SRAM_CTRL_BYTE_MASK_EN
    bs_eff = bs;
`else
    bs_eff = 2'b11;
`endif
    if (!r) begin
      if (cmd == C_W) begin
        ref_mem[a] = lane_mix(ref_mem[a], din, bs_eff);
      end else if (cmd == C_R) begin
        proj_dout = lane_mix(proj_dout, ref_mem[a], bs_eff);
        sb_q.push_back(proj_dout);
      end
    end
    @(posedge clk);
    #1;
    prev = exp_state;
    if (r) begin
      exp_state = T_IDLE;
      sb_q.delete();
      exp_dout  = 16'h0000;
      proj_dout = 16'h0000;
    end else begin
      exp_state = cmd_state(cmd);
      if (prev == T_READ) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", 16'h0001, 16'h0000);
        end else begin
          exp_dout = sb_q.pop_front();
        end
      end
    end
    exp_be = bs_eff;
    if (exp_state == T_WRITE) exp_wdata = din;
    tb_keep = (exp_state == T_IDLE);
    #1;
    check_eq("data_out", data_out, exp_dout);
    case (exp_state)
      T_WRITE: exp_pins = {1'b0, 1'b0, 1'b1, ~exp_be[0], ~exp_be[1]};
      T_READ:  exp_pins = {1'b0, 1'b1, 1'b0, ~exp_be[0], ~exp_be[1]};
      default: exp_pins = 5'b11111;
    endcase
    check_eq("pins_ce_we_oe_lb_ub", {11'd0, chip_en, data_enable, output_enable, LB, UB},
             {11'd0, exp_pins});
    if (exp_state == T_WRITE) begin
      check_eq("bus_write", bus, exp_wdata);
    end else if (exp_state == T_IDLE) begin
      check_eq("bus_released", bus, 16'h0000);
    end
  endtask

  logic [15:0] wr_data [10] = '{16'd1024, 16'd50612, 16'd255, 16'd12, 16'd6427,
                                16'd322, 16'd16, 16'd82, 16'd43, 16'd23};
  logic [7:0]  wr_addr [10] = '{8'd233, 8'd252, 8'd255, 8'd128, 8'd64,
                                8'd32, 8'd16, 8'd8, 8'd4, 8'd2};

  initial begin
    rst      = 1'b1;
    write_en = C_W;
    data_in  = 16'h0000;
    addr_req = 8'd0;
    byte_sel = 2'b11;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    // Reset wins over a WRITE command.
    step(C_W, 16'h1234, 8'd0, 1'b1, 2'b11);
    step(C_W, 16'h1234, 8'd0, 1'b1, 2'b11);

    // Writes alternating with idle (first pair is the single-write case).
    for (int i = 0; i < 10; i++) begin
      step(C_W, wr_data[i], wr_addr[i], 1'b0, 2'b11);
      step((i == 5) ? C_X : C_I, 16'hFFFF, wr_addr[i], 1'b0, 2'b11);
    end

    // Read back in reverse address order.
    for (int i = 9; i >= 0; i--) begin
      step(C_R, 16'h0000, wr_addr[i], 1'b0, 2'b11);
      step(C_I, 16'h0000, wr_addr[i], 1'b0, 2'b11);
    end

    // Back-to-back writes, back-to-back reads, then a write and idle.
    step(C_W, 16'hAAAA, 8'd10, 1'b0, 2'b11);
    step(C_W, 16'h5555, 8'd11, 1'b0, 2'b11);
    step(C_R, 16'h0000, 8'd10, 1'b0, 2'b11);
    step(C_R, 16'h0000, 8'd11, 1'b0, 2'b11);
    step(C_W, 16'h7777, 8'd12, 1'b0, 2'b11);
    step(C_I, 16'h0000, 8'd12, 1'b0, 2'b11);

    // Reset discards a pending capture, then aborts an in-flight write.
    step(C_R, 16'h0000, 8'd233, 1'b0, 2'b11);
    step(C_W, 16'h0F0F, 8'd40, 1'b1, 2'b11);
    step(C_W, 16'h1111, 8'd40, 1'b0, 2'b11);
    step(C_W, 16'h2222, 8'd41, 1'b1, 2'b11);
    step(C_I, 16'h0000, 8'd41, 1'b0, 2'b11);
    step(C_R, 16'h0000, 8'd40, 1'b0, 2'b11);
    step(C_I, 16'h0000, 8'd40, 1'b0, 2'b11);

    // Lane select on read (full-width behaviour when the option is off).
    step(C_W, 16'h1234, 8'd20, 1'b0, 2'b11);
    step(C_I, 16'h0000, 8'd20, 1'b0, 2'b11);
    step(C_R, 16'h0000, 8'd20, 1'b0, 2'b11);
    step(C_I, 16'h0000, 8'd20, 1'b0, 2'b11);
    step(C_W, 16'hABCD, 8'd21, 1'b0, 2'b11);
    step(C_I, 16'h0000, 8'd21, 1'b0, 2'b11);
    step(C_R, 16'h0000, 8'd21, 1'b0, 2'b01);
    step(C_I, 16'h0000, 8'd21, 1'b0, 2'b11);
    step(C_W, 16'h9999, 8'd22, 1'b0, 2'b10);
    step(C_I, 16'h0000, 8'd22, 1'b0, 2'b11);

    check_eq("sb_drained", 16'(sb_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Registered command-to-pin controller for an asynchronous 16-bit SRAM with active-low controls (CE#, WE#, OE#, LB#, UB#) and a shared bidirectional data bus.
- A 2-bit command selects write, read or idle each cycle. The block drives the SRAM strobes and tri-state bus, and captures read data into a holding register.
- The SRAM address is supplied externally by the sequencer and does not pass through this block.

Parameters:
- DATA_W, 16, data bus width; LB# covers [7:0] and UB# covers [DATA_W-1:8].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  2  command: 2'b11 = WRITE, 2'b00 = READ, 2'b10 = IDLE, 2'b01 = treated as IDLE.
- data_in  in  DATA_W  write data, sampled with a WRITE command.
- bus  inout  DATA_W  SRAM data pins; driven only in the WRITE state, high-Z otherwise.
- data_out  out  DATA_W  last captured read word.
- chip_en  out  1  SRAM CE#, active low.
- data_enable  out  1  SRAM WE#, active low.
- output_enable  out  1  SRAM OE#, active low.
- LB  out  1  lower-byte enable, active low.
- UB  out  1  upper-byte enable, active low.

Behaviour:
- All outputs are registered; there is no combinational path from write_en or data_in to any pin.
- Reset (synchronous, highest priority; it overrides any command in the same cycle):
  - state = IDLE; chip_en = data_enable = output_enable = 1; LB = UB = 1.
  - bus driver off; write-data register = 0; data_out = 0.
- States: IDLE, WRITE, READ. The next state is the decoded write_en sampled at each edge; there is no further sequencing, so any state follows any state.
- WRITE, entered at edge N:
  - after edge N: chip_en = 0, data_enable = 0, output_enable = 1, LB = UB = 0.
  - bus driven with the data_in value sampled at edge N.
- READ, entered at edge N:
  - after edge N: chip_en = 0, data_enable = 1, output_enable = 0, LB = UB = 0; bus high-Z.
- IDLE:
  - chip_en = 1, data_enable = 1, output_enable = 1, LB = UB = 1; bus high-Z.
- Read capture: at any edge where the current state is READ, data_out <= bus.
  - data_out is valid one cycle after the READ state begins; read latency is 2 edges from command sample.
  - data_out holds its value in all other cycles, across writes and idles, until the next capture.
- Back-to-back commands:
  - READ to READ: one capture per READ cycle.
  - WRITE to WRITE: a new word every cycle.
  - READ to WRITE: the bus driver enables at the same edge that OE# deasserts; the sequencer inserts an IDLE when board timing requires.
- Reset mid-operation: the in-flight write is aborted (WE# rises, bus released) and any pending capture is discarded.

Optional Feature:
- Macro: SRAM_CTRL_BYTE_MASK_EN.
- With the macro defined:
  - an extra input byte_sel[1:0] is added; bit0 = lower byte, bit1 = upper byte, active high.
  - byte_sel is sampled together with write_en. In WRITE/READ, LB = ~byte_sel[0] and UB = ~byte_sel[1].
  - on read, unselected byte lanes of data_out keep their previous value.
- Without the macro: no port is added; LB and UB are low in WRITE/READ and high in IDLE/reset.

Decomposition:
- Package sram_ctrl_pkg:
  - DATA_W default.
  - command constants CMD_WRITE = 2'b11, CMD_READ = 2'b00, CMD_IDLE = 2'b10.
  - state enum {S_IDLE, S_WRITE, S_READ}.
- One natural sub-module, sram_io_pad: the tri-state bus driver (out data, out enable, in data), keeping the inout isolated from the control FSM.

Test Plan:
- Reset: hold rst = 1 with write_en = 2'b11 -> chip_en = data_enable = output_enable = LB = UB = 1, bus = Z, data_out = 0.
- Single write: write_en = 11, data_in = 16'd1024, then write_en = 10 -> during WRITE bus = 1024, WE# = 0, OE# = 1, CE# = 0; in IDLE bus = Z, all strobes = 1.
- Write/read: alternate WRITE/IDLE for data 1024, 50612, 255, 12, 6427, 322, 16, 82, 43, 23 into an SRAM model at addresses 233, 252, 255, 128, 64, 32, 16, 8, 4, 2. Then alternate READ/IDLE in reverse address order -> data_out = 23, 43, 82, 16, 322, 6427, 12, 255, 50612, 1024, each valid one cycle after its READ state.
- Back-to-back: READ, READ at two addresses holding 0xAAAA and 0x5555 -> data_out = 0xAAAA then 0x5555 on consecutive edges; data_out holds through a following WRITE.
- Reset mid-write: assert rst in a WRITE cycle -> next edge WE# = 1, bus = Z, data_out = 0.
- Byte mask (SRAM_CTRL_BYTE_MASK_EN defined): READ with byte_sel = 2'b01, data_out = 0x1234, SRAM word 0xABCD -> LB = 0, UB = 1, data_out = 0x12CD.
